tow_rope_ctrl: RTL and testbench



---
 rtl/tow_rope_ctrl_pkg.sv | 20 ++
 rtl/tow_rope_ctrl_if.sv | 27 ++
 rtl/tow_hold_timer.sv | 41 ++++
 rtl/tow_rope_ctrl.sv | 167 ++++++++++++++++
 tb/tb_tow_rope_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/tow_rope_ctrl_pkg.sv
// Shared tug-of-war game definitions: round FSM states and rope geometry helpers.
package tow_rope_ctrl_pkg;

    // Round sequencing: re-arm after release, debounce the press, apply it, or stop on a win.
    typedef enum logic [2:0] {
        StRelease,
        StArmed,
        StSettle,
        StResolve,
        StWin
    } tow_state_e;

    localparam int unsigned N_POS_DEFAULT = 9;

    // Index of the middle LED; the rope starts and restarts here.
    function automatic int unsigned centre_pos(input int unsigned n_pos);
        return (n_pos - 1) / 2;
    endfunction

endpackage

// File: rtl/tow_rope_ctrl_if.sv
// Latch-to-controller bundle: press status in, latch clear and game display out.
interface tow_rope_ctrl_if #(
    parameter int unsigned N_POS = 9,
    parameter int unsigned CNT_W = 8
);
    logic             push;
    logic             tie;
    logic             right;
    logic             clr;
    logic [N_POS-1:0] leds;
    logic             tie_pulse;
    logic             win_valid;
    logic             win_right;
    logic [CNT_W-1:0] rounds;

    // Driver of the press inputs (latch side or bench).
    modport master (
        output push, tie, right,
        input  clr, leds, tie_pulse, win_valid, win_right, rounds
    );

    // The rope controller.
    modport slave (
        input  push, tie, right,
        output clr, leds, tie_pulse, win_valid, win_right, rounds
    );
endinterface

// File: rtl/tow_hold_timer.sv
// Loadable up-counter with clear and terminal-count flag, used to time press/release windows.
module tow_hold_timer #(
    parameter int unsigned W        = 3,
    parameter int unsigned Terminal = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_d, cnt_q;

    // Next count: clear wins over load, load wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == W'(Terminal));

endmodule

// File: rtl/tow_rope_ctrl.sv
// Tug-of-war rope controller: one debounced round per latched press, marker moves toward the
// press winner, game stops when the marker reaches an end.
module tow_rope_ctrl
    import tow_rope_ctrl_pkg::*;
#(
    parameter int unsigned N_POS          = N_POS_DEFAULT,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned RELEASE_CYCLES = 4,
    parameter int unsigned CNT_W          = 8
) (
    input logic           clk,
    input logic           rst,
    tow_rope_ctrl_if.slave bus
);
    localparam int unsigned Centre = centre_pos(N_POS);
    localparam int unsigned PosW   = $clog2(N_POS);
    localparam int unsigned MaxWin = (SETTLE_CYCLES > RELEASE_CYCLES) ? SETTLE_CYCLES
                                                                       : RELEASE_CYCLES;
    localparam int unsigned TimerW = $clog2(MaxWin + 1);

    tow_state_e       state_d, state_q;
    logic [PosW-1:0]  pos_d, pos_q;
    logic [N_POS-1:0] leds_d, leds_q;
    logic             clr_d, clr_q;
    logic             tie_pulse_d, tie_pulse_q;
    logic             win_valid_d, win_valid_q;
    logic             win_right_d, win_right_q;
    logic [CNT_W-1:0] rounds_d, rounds_q;
    logic             samp_tie_d, samp_tie_q;
    logic             samp_right_d, samp_right_q;

    logic              settle_clr, settle_tc;
    logic              rel_clr, rel_tc;
    logic [TimerW-1:0] settle_cnt, rel_cnt;

    // Window timers run only in their own state and restart whenever the push level breaks.
    assign settle_clr = (state_q != StSettle) || !bus.push || settle_tc;
    assign rel_clr    = (state_q != StRelease) || bus.push || rel_tc;

    tow_hold_timer #(
        .W        (TimerW),
        .Terminal (SETTLE_CYCLES - 1)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (settle_clr),
        .inc_i      (!settle_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .cnt_o      (settle_cnt),
        .tc_o       (settle_tc)
    );

    tow_hold_timer #(
        .W        (TimerW),
        .Terminal (RELEASE_CYCLES - 1)
    ) u_release_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (rel_clr),
        .inc_i      (!rel_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .cnt_o      (rel_cnt),
        .tc_o       (rel_tc)
    );

    // Round sequencing and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        tie_pulse_d  = 1'b0;
        win_valid_d  = win_valid_q;
        win_right_d  = win_right_q;
        rounds_d     = rounds_q;
        samp_tie_d   = samp_tie_q;
        samp_right_d = samp_right_q;

        unique case (state_q)
            StRelease: begin
                if (!bus.push && rel_tc) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (bus.push) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (!bus.push) begin
                    state_d = StArmed;
                end else if (settle_tc) begin
                    state_d      = StResolve;
                    samp_tie_d   = bus.tie;
                    samp_right_d = bus.right;
                    // Pulse is registered so it is visible during the resolve cycle itself.
                    tie_pulse_d  = bus.tie;
                end
            end
            StResolve: begin
                if (samp_tie_q) begin
                    pos_d = pos_q;
                end else if (samp_right_q) begin
                    pos_d = pos_q + PosW'(1);
                end else begin
                    pos_d = pos_q - PosW'(1);
                end
                if (rounds_q != '1) begin
                    rounds_d = rounds_q + CNT_W'(1);
                end
                if ((pos_d == '0) || (pos_d == PosW'(N_POS - 1))) begin
                    state_d     = StWin;
                    win_valid_d = 1'b1;
                    win_right_d = (pos_d == PosW'(N_POS - 1));
                end else begin
                    state_d = StRelease;
                end
            end
            StWin: begin
                state_d = StWin;
            end
            default: begin
                state_d = StRelease;
            end
        endcase

        clr_d  = (state_d == StRelease) || (state_d == StWin);
        leds_d = '0;
        leds_d[pos_d] = 1'b1;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRelease;
            pos_q        <= PosW'(Centre);
            leds_q       <= N_POS'(1) << Centre;
            clr_q        <= 1'b1;
            tie_pulse_q  <= 1'b0;
            win_valid_q  <= 1'b0;
            win_right_q  <= 1'b0;
            rounds_q     <= '0;
            samp_tie_q   <= 1'b0;
            samp_right_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            leds_q       <= leds_d;
            clr_q        <= clr_d;
            tie_pulse_q  <= tie_pulse_d;
            win_valid_q  <= win_valid_d;
            win_right_q  <= win_right_d;
            rounds_q     <= rounds_d;
            samp_tie_q   <= samp_tie_d;
            samp_right_q <= samp_right_d;
        end
    end

    assign bus.clr       = clr_q;
    assign bus.leds      = leds_q;
    assign bus.tie_pulse = tie_pulse_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_right = win_right_q;
    assign bus.rounds    = rounds_q;

endmodule

// File: tb/tb_tow_rope_ctrl.sv
// Bench for tow_rope_ctrl: directed vector table, hand sequences for win and async reset,
// then randomized press/release runs against a run-length reference model.
module tb_tow_rope_ctrl;
    localparam int unsigned NPos    = 9;
    localparam int unsigned Settle  = 4;
    localparam int unsigned Release = 4;
    localparam int unsigned CntW    = 8;
    localparam int unsigned Mid     = (NPos - 1) / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    tow_rope_ctrl_if #(.N_POS(NPos), .CNT_W(CntW)) bus ();

    tow_rope_ctrl #(
        .N_POS          (NPos),
        .SETTLE_CYCLES  (Settle),
        .RELEASE_CYCLES (Release),
        .CNT_W          (CntW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference model: press accepted after Settle+1 consecutive high cycles while armed,
    // re-armed after Release consecutive low cycles, one dead cycle to apply the move.
    int m_pos, m_rounds, m_hi, m_lo;
    bit m_won, m_armed, m_pend, m_pt, m_pr;

    task automatic model_reset();
        m_pos = Mid; m_rounds = 0; m_hi = 0; m_lo = 0;
        m_won = 0; m_armed = 0; m_pend = 0; m_pt = 0; m_pr = 0;
    endtask

    task automatic model_step(input bit p, input bit t, input bit r);
        if (m_won) begin
            // game over: nothing moves
        end else if (m_pend) begin
            m_pend = 0;
            if (!m_pt) m_pos = m_pr ? m_pos + 1 : m_pos - 1;
            if (m_rounds < 255) m_rounds++;
            if (m_pos == 0 || m_pos == NPos - 1) m_won = 1;
            m_lo = 0;
        end else if (m_armed) begin
            m_hi = p ? m_hi + 1 : 0;
            if (m_hi == Settle + 1) begin
                m_pend = 1; m_pt = t; m_pr = r; m_armed = 0; m_hi = 0;
            end
        end else begin
            m_lo = p ? 0 : m_lo + 1;
            if (m_lo == Release) begin
                m_armed = 1; m_lo = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " leds"}, 32'(bus.leds), 32'(1) << m_pos);
        check({tag, " clr"}, 32'(bus.clr), 32'(m_won || (!m_armed && !m_pend)));
        check({tag, " tie_pulse"}, 32'(bus.tie_pulse), 32'(m_pend && m_pt));
        check({tag, " win_valid"}, 32'(bus.win_valid), 32'(m_won));
        check({tag, " win_right"}, 32'(bus.win_right), 32'(m_won && m_pos == NPos - 1));
        check({tag, " rounds"}, 32'(bus.rounds), 32'(m_rounds));
    endtask

    // Drive inputs away from the edge, clock once, advance the model.
    task automatic apply(input bit p, input bit t, input bit r);
        bus.push = p; bus.tie = t; bus.right = r;
        @(posedge clk);
        model_step(p, t, r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.push = 0; bus.tie = 0; bus.right = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic press(input int hi_len, input int lo_len, input bit t, input bit r,
                         input string tag);
        for (int k = 0; k < hi_len; k++) begin
            apply(1, t, r);
            check_model(tag);
        end
        for (int k = 0; k < lo_len; k++) begin
            apply(0, 0, 0);
            check_model(tag);
        end
    endtask

    typedef struct {
        bit         p, t, r;
        logic [8:0] leds;
        logic       clr, tp, wv;
        logic [7:0] rounds;
    } vec_t;

    function automatic vec_t mk(bit p, bit t, bit r, logic [8:0] leds, logic clr, logic tp,
                                logic wv, logic [7:0] rounds);
        vec_t v;
        v.p = p; v.t = t; v.r = r; v.leds = leds; v.clr = clr; v.tp = tp; v.wv = wv;
        v.rounds = rounds;
        return v;
    endfunction

    vec_t tbl[24];

    initial begin
        logic [8:0] ctr_leds;
        logic [8:0] right1;
        ctr_leds = 9'b000010000;
        right1   = 9'b000100000;

        // release window, right press held 6, release, short glitch, tie press held 5
        for (int i = 0; i < 3; i++) tbl[i] = mk(0, 0, 0, ctr_leds, 1, 0, 0, 0);
        tbl[3] = mk(0, 0, 0, ctr_leds, 0, 0, 0, 0);
        for (int i = 4; i < 9; i++) tbl[i] = mk(1, 0, 1, ctr_leds, 0, 0, 0, 0);
        tbl[9] = mk(1, 0, 1, right1, 1, 0, 0, 1);
        for (int i = 10; i < 13; i++) tbl[i] = mk(0, 0, 0, right1, 1, 0, 0, 1);
        tbl[13] = mk(0, 0, 0, right1, 0, 0, 0, 1);
        tbl[14] = mk(1, 0, 0, right1, 0, 0, 0, 1);
        tbl[15] = mk(1, 0, 0, right1, 0, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, right1, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 0, right1, 0, 0, 0, 1);
        for (int i = 18; i < 22; i++) tbl[i] = mk(1, 1, 0, right1, 0, 0, 0, 1);
        tbl[22] = mk(1, 1, 0, right1, 0, 1, 0, 1);
        tbl[23] = mk(0, 0, 0, right1, 1, 0, 0, 2);

        bus.push = 0; bus.tie = 0; bus.right = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset leds", 32'(bus.leds), 32'(ctr_leds));
        check("reset clr", 32'(bus.clr), 32'd1);
        check("reset rounds", 32'(bus.rounds), 32'd0);
        check("reset win_valid", 32'(bus.win_valid), 32'd0);
        check("reset tie_pulse", 32'(bus.tie_pulse), 32'd0);

        for (int i = 0; i < 24; i++) begin
            apply(tbl[i].p, tbl[i].t, tbl[i].r);
            check($sformatf("vec%0d leds", i), 32'(bus.leds), 32'(tbl[i].leds));
            check($sformatf("vec%0d clr", i), 32'(bus.clr), 32'(tbl[i].clr));
            check($sformatf("vec%0d tie_pulse", i), 32'(bus.tie_pulse), 32'(tbl[i].tp));
            check($sformatf("vec%0d win_valid", i), 32'(bus.win_valid), 32'(tbl[i].wv));
            check($sformatf("vec%0d rounds", i), 32'(bus.rounds), 32'(tbl[i].rounds));
        end

        // Four left presses from centre reach the far-left end.
        do_reset();
        press(0, Release, 0, 0, "win arm");
        for (int n = 0; n < 4; n++) press(Settle + 1, Release + 1, 0, 0, "win left");
        check("left win leds", 32'(bus.leds), 32'h001);
        check("left win valid", 32'(bus.win_valid), 32'd1);
        check("left win right", 32'(bus.win_right), 32'd0);
        check("left win clr", 32'(bus.clr), 32'd1);
        check("left win rounds", 32'(bus.rounds), 32'd4);
        for (int n = 0; n < 3; n++) press(Settle + 3, Release + 1, 0, 1, "after win");
        check("frozen leds", 32'(bus.leds), 32'h001);
        check("frozen rounds", 32'(bus.rounds), 32'd4);

        // Async reset in the middle of a settle window after two right moves.
        do_reset();
        press(0, Release, 0, 0, "rst arm");
        for (int n = 0; n < 2; n++) press(Settle + 1, Release + 1, 0, 1, "rst right");
        check("pre-rst leds", 32'(bus.leds), 32'h040);
        press(3, 0, 0, 1, "rst settle");
        #2 rst = 1'b1;
        #1;
        check("async rst leds", 32'(bus.leds), 32'(ctr_leds));
        check("async rst rounds", 32'(bus.rounds), 32'd0);
        check("async rst clr", 32'(bus.clr), 32'd1);
        check("async rst win_valid", 32'(bus.win_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        press(0, Release, 0, 0, "post rst");

        // Random press/release runs; ties about a quarter of the time.
        for (int g = 0; g < 25; g++) begin
            do_reset();
            for (int n = 0; n < 30; n++) begin
                bit t;
                bit r;
                t = ($urandom_range(0, 3) == 0);
                r = t ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 1));
                press($urandom_range(1, 8), $urandom_range(1, 7), t, r,
                      $sformatf("rnd g%0d n%0d", g, n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
